ads412x_cfg_ctrl: RTL and testbench



---
 rtl/ads412x_cfg_pkg.sv | 23 ++
 rtl/ads412x_cfg_ctrl_spi_shift.sv | 67 ++++++
 rtl/ads412x_cfg_ctrl.sv | 98 +++++++++
 tb/tb_ads412x_cfg_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ads412x_cfg_pkg.sv
// ads412x_cfg_pkg: shared state encoding, frame width and startup register table for the ADS412x config sequencer.
package ads412x_cfg_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [2:0] {
        ST_RST_P,
        ST_RST_W,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP_W,
        ST_DONE
    } state_t;

    localparam logic [FRAME_W-1:0] ADS_CFG_TABLE [16] = '{
        0: 16'h4208,
        1: 16'h2500,
        2: 16'h3D00,
        3: 16'h4100,
        default: 16'h0000
    };

endpackage

// File: rtl/ads412x_cfg_ctrl_spi_shift.sv
// ads412x_spi_shift: shifts one 16-bit {addr,data} frame MSB first on SCLK/SDATA/SEN and flags its final cycle.
module ads412x_spi_shift
    import ads412x_cfg_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic               clk_in,
    input  logic               RST,
    input  logic               start,
    input  logic [FRAME_W-1:0] word,
    output logic               sclk,
    output logic               sdata,
    output logic               sen,
    output logic               done
);

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic               active;
    logic [DW-1:0]      div_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               div_end;

    assign div_end = div_cnt == DW'(CLK_DIV - 1);
    // Asserted in the last high-phase cycle so the FSM leaves SHIFT on the same edge SEN rises.
    assign done    = active && sclk && div_end && bit_cnt == 4'd15;

    always_ff @(posedge clk_in) begin
        if (RST) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            sen     <= 1'b1;
            sdata   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sen     <= 1'b0;
            sclk    <= 1'b0;
            sdata   <= word[FRAME_W-1];
            shreg   <= word;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            div_cnt <= div_end ? '0 : div_cnt + DW'(1);
            if (div_end) begin
                if (!sclk) begin
                    sclk <= 1'b1;
                end else if (bit_cnt == 4'd15) begin
                    active  <= 1'b0;
                    sclk    <= 1'b0;
                    sen     <= 1'b1;
                    sdata   <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    sclk    <= 1'b0;
                    bit_cnt <= bit_cnt + 4'd1;
                    sdata   <= shreg[FRAME_W-2];
                    shreg   <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: rtl/ads412x_cfg_ctrl.sv
// ads412x_cfg_ctrl: ADS412x reset pulse, startup register table load and run-time register writes over the 3-wire port.
module ads412x_cfg_ctrl
    import ads412x_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 5,
    parameter int RST_PULSE = 10,
    parameter int RST_WAIT  = 100,
    parameter int GAP       = 4,
    parameter int NUM_REGS  = 4
) (
    input  logic       clk_in,
    input  logic       RST,
    input  logic       cfg_restart,
    input  logic       wr_valid,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       cfg_done,
    output logic       cfg_busy,
    output logic       adc_reset,
    output logic       adc_sen,
    output logic       adc_sclk,
    output logic       adc_sdata
);

    localparam int CMAX = RST_PULSE > RST_WAIT ? (RST_PULSE > GAP ? RST_PULSE : GAP)
                                               : (RST_WAIT > GAP ? RST_WAIT : GAP);
    localparam int CW   = $clog2(CMAX + 1);

    state_t             state, next_state;
    logic [CW-1:0]      cnt;
    logic [3:0]         idx;
    logic               rt;
    logic               start;
    logic               spi_done;
    logic [FRAME_W-1:0] word;

    always_comb begin
        next_state = state;
        start      = 1'b0;
        word       = {wr_addr, wr_data};
        case (state)
            ST_RST_P: next_state = cnt == CW'(RST_PULSE) ? ST_RST_W : ST_RST_P;
            ST_RST_W: next_state = cnt == CW'(RST_WAIT - 1) ? ST_LOAD : ST_RST_W;
            ST_LOAD: begin
                start      = 1'b1;
                word       = ADS_CFG_TABLE[idx];
                next_state = ST_SHIFT;
            end
            ST_SHIFT: next_state = spi_done ? ST_GAP_W : ST_SHIFT;
            ST_GAP_W: next_state = cnt != CW'(GAP - 1) ? ST_GAP_W :
                                   (rt || idx == 4'(NUM_REGS - 1)) ? ST_DONE : ST_LOAD;
            ST_DONE: begin
                start      = wr_valid && !cfg_restart;
                next_state = cfg_restart ? ST_RST_P : start ? ST_SHIFT : ST_DONE;
            end
            default: next_state = ST_RST_P;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state     <= ST_RST_P;
            cnt       <= '0;
            idx       <= '0;
            rt        <= 1'b0;
            adc_reset <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_busy  <= 1'b1;
            wr_ready  <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_state != state ? '0 : cnt + CW'(1);
            idx       <= next_state == ST_RST_P ? '0 :
                         (state == ST_GAP_W && next_state == ST_LOAD) ? idx + 4'd1 : idx;
            rt        <= state == ST_DONE ? 1'b1 : state == ST_LOAD ? 1'b0 : rt;
            adc_reset <= state == ST_RST_P && next_state == ST_RST_P;
            cfg_done  <= next_state == ST_DONE || (cfg_done && next_state != ST_RST_P);
            cfg_busy  <= next_state != ST_DONE;
            wr_ready  <= next_state == ST_DONE;
        end
    end

    ads412x_spi_shift #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .clk_in (clk_in),
        .RST    (RST),
        .start  (start),
        .word   (word),
        .sclk   (adc_sclk),
        .sdata  (adc_sdata),
        .sen    (adc_sen),
        .done   (spi_done)
    );

endmodule

// File: tb/tb_ads412x_cfg_ctrl.sv
// tb_ads412x_cfg_ctrl: scoreboard bench; stimulus queues expected frames, a monitor decodes the serial port and compares.
module tb_ads412x_cfg_ctrl;

    localparam int CD = 2;
    localparam int RP = 3;
    localparam int RW = 5;
    localparam int GP = 2;
    localparam int NR = 4;

    localparam logic [15:0] TBL [4] = '{16'h4208, 16'h2500, 16'h3D00, 16'h4100};

    logic       clk_in = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_restart = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, cfg_done, cfg_busy, adc_reset, adc_sen, adc_sclk, adc_sdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];

    ads412x_cfg_ctrl #(
        .CLK_DIV(CD), .RST_PULSE(RP), .RST_WAIT(RW), .GAP(GP), .NUM_REGS(NR)
    ) dut (
        .clk_in      (clk_in),
        .RST         (RST),
        .cfg_restart (cfg_restart),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .cfg_done    (cfg_done),
        .cfg_busy    (cfg_busy),
        .adc_reset   (adc_reset),
        .adc_sen     (adc_sen),
        .adc_sclk    (adc_sclk),
        .adc_sdata   (adc_sdata)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Serial-port monitor: frame decode, scoreboard pop, SCLK/SDATA protocol and reset-pulse width.
    logic        p_sclk = 1'b0, p_sen = 1'b1, p_sdata = 1'b0, p_rst = 1'b0;
    logic [15:0] sh = 16'h0;
    int          nbits = 0, sen_low = 0, full = 0, partial = 0, rst_len = 0;
    int          last_rise = -100, last_chg = -100;

    always @(negedge clk_in) begin
        if (!RST) chk("ready_only_when_done", {31'b0, wr_ready && !cfg_done}, 0);
        if (!adc_sen) begin
            sen_low++;
            if (p_sen) last_chg = cyc;
            else if (adc_sdata !== p_sdata) begin
                chk("sdata_hold_after_rise", {31'b0, (cyc - last_rise) >= CD}, 1);
                last_chg = cyc;
            end
            if (adc_sclk && !p_sclk) begin
                chk("sdata_setup_before_rise", {31'b0, (cyc - last_chg) >= CD}, 1);
                sh = {sh[14:0], adc_sdata};
                nbits++;
                last_rise = cyc;
            end
        end else begin
            chk("sclk_idle_when_sen_high", {31'b0, adc_sclk}, 0);
            if (!p_sen) begin
                if (nbits == 16) begin
                    full++;
                    chk("sen_low_window", sen_low, 32 * CD);
                    chk("frame_expected", {31'b0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0) chk("frame_word", {16'b0, sh}, {16'b0, exp_q.pop_front()});
                end else begin
                    partial++;
                end
            end
            nbits = 0;
            sen_low = 0;
        end
        if (adc_reset) rst_len++;
        else begin
            if (p_rst) chk("adc_reset_width", rst_len, RP);
            rst_len = 0;
        end
        p_sclk = adc_sclk;
        p_sen = adc_sen;
        p_sdata = adc_sdata;
        p_rst = adc_reset;
    end

    task automatic wait_done(input int max);
        for (int i = 0; i < max && !cfg_done; i++) @(negedge clk_in);
        chk("cfg_done_wait", {31'b0, cfg_done}, 1);
    endtask

    task automatic wait_ready(input int max);
        for (int i = 0; i < max && !wr_ready; i++) @(negedge clk_in);
        chk("wr_ready_wait", {31'b0, wr_ready}, 1);
    endtask

    task automatic push_table();
        for (int i = 0; i < NR; i++) exp_q.push_back(TBL[i]);
    endtask

    initial begin
        int t0, tf, f0;
        repeat (3) @(negedge clk_in);
        chk("rst_adc_reset", {31'b0, adc_reset}, 0);
        chk("rst_adc_sen", {31'b0, adc_sen}, 1);
        chk("rst_adc_sclk", {31'b0, adc_sclk}, 0);
        chk("rst_adc_sdata", {31'b0, adc_sdata}, 0);
        chk("rst_cfg_done", {31'b0, cfg_done}, 0);
        chk("rst_cfg_busy", {31'b0, cfg_busy}, 1);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);

        // Power-up: 3 + 5 + 4*67 = 276 cycles to cfg_done, within one cycle.
        push_table();
        t0 = cyc;
        RST = 1'b0;
        wait_done(600);
        chk("startup_length", {31'b0, (cyc - t0) >= 275 && (cyc - t0) <= 277}, 1);
        chk("busy_clear_in_done", {31'b0, cfg_busy}, 0);

        // Run-time write 1F/A5.
        wr_valid = 1'b1; wr_addr = 8'h1F; wr_data = 8'hA5;
        exp_q.push_back(16'h1FA5);
        @(negedge clk_in);
        wr_valid = 1'b0;
        chk("wr_ready_drop", {31'b0, wr_ready}, 0);
        chk("hs_to_sen_fall", {31'b0, adc_sen}, 0);
        tf = cyc;
        wait_ready(200);
        chk("write_cost", cyc - tf, 32 * CD + GP);
        chk("cfg_done_kept", {31'b0, cfg_done}, 1);
        chk("queue_after_write", exp_q.size(), 0);

        // Restart together with a write: restart wins, the held write is served once after the replay.
        cfg_restart = 1'b1; wr_valid = 1'b1; wr_addr = 8'h1F; wr_data = 8'hA5;
        push_table();
        exp_q.push_back(16'h1FA5);
        @(negedge clk_in);
        cfg_restart = 1'b0;
        chk("restart_ready_drop", {31'b0, wr_ready}, 0);
        chk("restart_done_clear", {31'b0, cfg_done}, 0);
        chk("restart_no_frame", {31'b0, adc_sen}, 1);
        chk("restart_busy", {31'b0, cfg_busy}, 1);
        wait_done(600);
        @(negedge clk_in);
        wr_valid = 1'b0;
        chk("held_hs_ready_drop", {31'b0, wr_ready}, 0);
        chk("held_hs_sen", {31'b0, adc_sen}, 0);
        wait_ready(200);
        chk("queue_after_held", exp_q.size(), 0);

        // RST in the middle of frame 2 of a replayed table.
        cfg_restart = 1'b1;
        exp_q.push_back(TBL[0]);
        f0 = full;
        @(negedge clk_in);
        cfg_restart = 1'b0;
        for (int i = 0; i < 600 && !(full == f0 + 1 && nbits == 8); i++) @(negedge clk_in);
        chk("reach_frame2_bit7", {31'b0, full == f0 + 1 && nbits == 8}, 1);
        RST = 1'b1;
        @(negedge clk_in);
        chk("abort_sen", {31'b0, adc_sen}, 1);
        chk("abort_sclk", {31'b0, adc_sclk}, 0);
        chk("abort_sdata", {31'b0, adc_sdata}, 0);
        chk("abort_done", {31'b0, cfg_done}, 0);
        repeat (2) @(negedge clk_in);
        push_table();
        RST = 1'b0;
        wait_done(600);

        repeat (4) @(negedge clk_in);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("partial_frames", partial, 1);
        chk("full_frames", full, 15);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
